// File: rtl/period_meter.sv
// period_meter
//   Measures the rising-to-rising period and the high-phase length of an
//   asynchronous input in clk cycles, flags a timeout when no rising edge is
//   seen within 2^CNT_W-1 cycles, and reports when the last STABLE_CNT
//   periods were identical.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   sig_in     in   measured signal, asynchronous to clk
//   period     out  [CNT_W-1:0] last measured rise-to-rise interval
//   high_time  out  [CNT_W-1:0] high-phase length of that same cycle
//   valid      out  one-cycle pulse when period/high_time update
//   ovf        out  level, timed out; clears with the next report
//   stable     out  level, last STABLE_CNT reported periods identical
module period_meter #(
  parameter int CNT_W      = 16,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             ovf,
  output logic             stable
);

  localparam int MW = $clog2(STABLE_CNT);
  localparam logic [MW-1:0]    MATCH_MAX = MW'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;
  localparam logic [1:0] S_OVF  = 2'd3;

  // Input front end
  logic       sync1_q, sync2_q, hist_q;
  logic [1:0] init_q;
  logic       seen_low_q;
  logic       rise_q, fall_q;
  logic       rise, fall;

  assign rise = sync2_q & ~hist_q;
  assign fall = ~sync2_q & hist_q;

  // init_q[1] marks that sync2_q holds a real sample of sig_in rather than
  // its reset value. A rise only counts once sig_in has been seen low, so a
  // signal already high at reset release is not mistaken for a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      hist_q     <= 1'b0;
      init_q     <= '0;
      seen_low_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      sync1_q    <= sig_in;
      sync2_q    <= sync1_q;
      hist_q     <= sync2_q;
      init_q     <= {init_q[0], 1'b1};
      seen_low_q <= seen_low_q | (init_q[1] & ~sync2_q);
      rise_q     <= rise & seen_low_q;
      fall_q     <= fall;
    end
  end

  // Measurement FSM
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
  logic             rpt_q, rpt_d;
  logic [CNT_W-1:0] rpt_per_q, rpt_per_d;
  logic [CNT_W-1:0] rpt_hi_q, rpt_hi_d;
  logic             to_q, to_d;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_cap_d  = hi_cap_q;
    rpt_d     = 1'b0;
    rpt_per_d = rpt_per_q;
    rpt_hi_d  = rpt_hi_q;
    to_d      = 1'b0;
    case (state_q)
      S_IDLE, S_OVF: begin
        if (rise_q) begin
          cnt_d   = CNT_ONE;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (rise_q) begin
          // Rise without a preceding fall: restart without reporting.
          cnt_d = CNT_ONE;
        end else if (fall_q) begin
          hi_cap_d = cnt_q;
          cnt_d    = cnt_inc;
          state_d  = S_LOW;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_OVF;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_LOW: begin
        // Rise is tested before the timeout so a period of exactly CNT_MAX
        // still reports.
        if (rise_q) begin
          rpt_d     = 1'b1;
          rpt_per_d = cnt_q;
          rpt_hi_d  = hi_cap_q;
          cnt_d     = CNT_ONE;
          state_d   = S_HIGH;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_OVF;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_cap_q  <= '0;
      rpt_q     <= 1'b0;
      rpt_per_q <= '0;
      rpt_hi_q  <= '0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_cap_q  <= hi_cap_d;
      rpt_q     <= rpt_d;
      rpt_per_q <= rpt_per_d;
      rpt_hi_q  <= rpt_hi_d;
      to_q      <= to_d;
    end
  end

  // Output and match stage
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             stable_q, stable_d;
  logic [MW-1:0]    match_q, match_d;
  logic             prev_vld_q, prev_vld_d;

  // prev_vld_q is cleared by reset and timeout so that the first report
  // afterwards never matches a stale period.
  always_comb begin
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    ovf_d      = ovf_q;
    stable_d   = stable_q;
    match_d    = match_q;
    prev_vld_d = prev_vld_q;
    if (rpt_q) begin
      valid_d    = 1'b1;
      period_d   = rpt_per_q;
      high_d     = rpt_hi_q;
      ovf_d      = 1'b0;
      prev_vld_d = 1'b1;
      if (prev_vld_q && (rpt_per_q == period_q)) begin
        match_d = (match_q == MATCH_MAX) ? match_q : match_q + 1'b1;
      end else begin
        match_d = '0;
      end
      stable_d = (match_d == MATCH_MAX);
    end else if (to_q) begin
      ovf_d      = 1'b1;
      stable_d   = 1'b0;
      match_d    = '0;
      prev_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      stable_q   <= 1'b0;
      match_q    <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      stable_q   <= stable_d;
      match_q    <= match_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign ovf       = ovf_q;
  assign stable    = stable_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: a 16-bit instance (default) and an 8-bit
// instance share clock, reset and sig_in. sig_in is driven on falling edges,
// so a rise set at a falling edge is sampled by the next rising edge k.
module tb_period_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sig;
  logic [15:0] per16, hi16;
  logic        v16, o16, s16;
  logic [7:0]  per8, hi8;
  logic        v8, o8, s8;

  period_meter #(.CNT_W(16), .STABLE_CNT(4)) dut16 (
    .clk(clk), .rst(rst), .sig_in(sig),
    .period(per16), .high_time(hi16), .valid(v16), .ovf(o16), .stable(s16)
  );

  period_meter #(.CNT_W(8), .STABLE_CNT(4)) dut8 (
    .clk(clk), .rst(rst), .sig_in(sig),
    .period(per8), .high_time(hi8), .valid(v8), .ovf(o8), .stable(s8)
  );

  typedef struct {
    int per;
    int hi;
    int st;
    int ov;
  } rep_t;

  rep_t q16[$];
  rep_t q8[$];
  int checks_n = 0;
  int errors_n = 0;

  // Report collector
  always @(posedge clk) begin : mon
    rep_t r;
    #1;
    if (v16 === 1'b1) begin
      r.per = int'(per16); r.hi = int'(hi16); r.st = int'(s16); r.ov = int'(o16);
      q16.push_back(r);
    end
    if (v8 === 1'b1) begin
      r.per = int'(per8); r.hi = int'(hi8); r.st = int'(s8); r.ov = int'(o8);
      q8.push_back(r);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_rep(input string tag, input int is8, input int idx,
                         input int per, input int hi, input int st, input int ov);
    rep_t r;
    int   n;
    n = (is8 != 0) ? q8.size() : q16.size();
    if (idx >= n) begin
      chk($sformatf("%s[%0d].present", tag, idx), 0, 1);
    end else begin
      r = (is8 != 0) ? q8[idx] : q16[idx];
      chk($sformatf("%s[%0d].period", tag, idx), r.per, per);
      chk($sformatf("%s[%0d].high", tag, idx), r.hi, hi);
      chk($sformatf("%s[%0d].stable", tag, idx), r.st, st);
      chk($sformatf("%s[%0d].ovf", tag, idx), r.ov, ov);
    end
  endtask

  // Called at a falling edge; leaves sig low at the falling edge where the
  // next rise would be driven, so rise spacing is hi+lo cycles.
  task automatic pulse(input int hi, input int lo);
    sig = 1'b1;
    repeat (hi) @(negedge clk);
    sig = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sig = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    q16.delete();
    q8.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks_n);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    sig = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.period", per16, 0);
    chk("rst.high", hi16, 0);
    chk("rst.valid", v16, 0);
    chk("rst.ovf", o16, 0);
    chk("rst.stable", s16, 0);
    chk("rst.period8", per8, 0);

    // Period 10 / high 5 lock
    do_reset();
    repeat (6) pulse(5, 5);
    chk("p10.count", q16.size(), 5);
    chk_rep("p10", 0, 0, 10, 5, 0, 0);
    chk_rep("p10", 0, 2, 10, 5, 0, 0);
    chk_rep("p10", 0, 3, 10, 5, 1, 0);
    chk_rep("p10", 0, 4, 10, 5, 1, 0);

    // Latency: rise sampled at edge k, valid high only after edge k+4
    sig = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("lat.valid%0d", i), v16, (i == 4) ? 1 : 0);
      if (i == 4) chk("lat.period", per16, 10);
      @(negedge clk);
      if (i == 4) sig = 1'b0;
    end
    repeat (4) @(negedge clk);

    // Switch to period 12 / high 4
    q16.delete();
    repeat (5) pulse(4, 8);
    pulse(5, 5);
    repeat (8) @(negedge clk);
    chk("p12.count", q16.size(), 6);
    chk_rep("p12", 0, 0, 10, 5, 1, 0);
    chk_rep("p12", 0, 1, 12, 4, 0, 0);
    chk_rep("p12", 0, 3, 12, 4, 0, 0);
    chk_rep("p12", 0, 4, 12, 4, 1, 0);

    // Reset mid-high-phase, sig still high at release
    do_reset();
    repeat (5) pulse(5, 5);
    chk("rmid.locked", s16, 1);
    sig = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rmid.period", per16, 0);
    chk("rmid.high", hi16, 0);
    chk("rmid.stable", s16, 0);
    chk("rmid.ovf", o16, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q16.delete();
    repeat (8) @(negedge clk);
    sig = 1'b0;
    repeat (5) @(negedge clk);
    chk("rmid.no_early", q16.size(), 0);
    repeat (6) pulse(5, 5);
    repeat (4) @(negedge clk);
    chk("rmid.count", q16.size(), 5);
    chk_rep("rmid", 0, 0, 10, 5, 0, 0);
    chk_rep("rmid", 0, 2, 10, 5, 0, 0);
    chk_rep("rmid", 0, 3, 10, 5, 1, 0);

    // CNT_W=8 overflow with sig held high
    do_reset();
    repeat (5) pulse(5, 5);
    sig = 1'b1;
    repeat (200) @(negedge clk);
    chk("ovf8.early", o8, 0);
    chk("ovf8.pre_stable", s8, 1);
    repeat (100) @(negedge clk);
    chk("ovf8.count", q8.size(), 5);
    chk("ovf8.ovf", o8, 1);
    chk("ovf8.stable", s8, 0);
    chk("ovf8.period", per8, 10);
    chk("ovf8.high", hi8, 5);
    sig = 1'b0;
    repeat (20) @(negedge clk);
    q8.delete();
    pulse(5, 5);
    chk("ovf8.rearm_none", q8.size(), 0);
    pulse(5, 5);
    repeat (10) @(negedge clk);
    chk("ovf8.after_count", q8.size(), 1);
    chk_rep("ovf8.after", 1, 0, 10, 5, 0, 0);
    chk("ovf8.cleared", o8, 0);

    // CNT_W=8 spacing exactly 255 reports; 256 times out
    do_reset();
    repeat (3) pulse(5, 250);
    pulse(5, 251);
    repeat (10) @(negedge clk);
    chk("max8.count", q8.size(), 3);
    chk_rep("max8", 1, 0, 255, 5, 0, 0);
    chk_rep("max8", 1, 2, 255, 5, 0, 0);
    chk("max8.ovf_256", o8, 1);
    chk("max8.period_kept", per8, 255);

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule
